// File: rtl/fetch_seq.sv
// fetch_seq: program-counter sequencer with conditional jump/call, a return-address
// stack (RAS) and sticky overflow/underflow flags. Define FETCH_SEQ_STALL_EN to enable stall.
module fetch_seq #(
  parameter int              PC_W        = 11,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC   = {PC_W{1'b0}},
  localparam int             DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               stall,
  input  logic               jump,
  input  logic               call,
  input  logic               ret,
  input  logic               cond,
  input  logic [PC_W-1:0]    target,
  output logic [PC_W-1:0]    pc,
  output logic [DEPTH_W-1:0] depth,
  output logic               ovf,
  output logic               unf
);

  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
  localparam logic [PC_W-1:0]    PC_ONE     = PC_W'(1);

  logic [PC_W-1:0]    ras [STACK_DEPTH];
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    pc_next;
  logic [PC_W-1:0]    ras_top;
  logic [DEPTH_W-1:0] depth_next;
  logic               ovf_next;
  logic               unf_next;
  logic               push;
  logic               hold;

`ifdef FETCH_SEQ_STALL_EN
  assign hold = stall;
`else
  logic stall_unused;
  assign stall_unused = stall;
  assign hold         = 1'b0;
`endif

  assign pc_inc = pc + PC_ONE;

  // Top-of-stack read (entry depth-1); zero when the stack is empty.
  always_comb begin
    ras_top = {PC_W{1'b0}};
    for (int i = 0; i < STACK_DEPTH; i++) begin
      ras_top = ras_top | ((int'(depth) == i + 1) ? ras[i] : {PC_W{1'b0}});
    end
  end

  // Next-state selection in priority order: stall, ret, taken call, taken jump, increment.
  always_comb begin
    pc_next    = pc;
    depth_next = depth;
    ovf_next   = ovf;
    unf_next   = unf;
    push       = 1'b0;
    if (hold) begin
      pc_next = pc;
    end else if (ret) begin
      if (depth != {DEPTH_W{1'b0}}) begin
        pc_next    = ras_top;
        depth_next = depth - DEPTH_ONE;
      end else begin
        pc_next  = pc_inc;
        unf_next = 1'b1;
      end
    end else if (call && cond) begin
      pc_next = target;
      if (depth != DEPTH_FULL) begin
        push       = 1'b1;
        depth_next = depth + DEPTH_ONE;
      end else begin
        ovf_next = 1'b1;
      end
    end else if (jump && cond) begin
      pc_next = target;
    end else begin
      pc_next = pc_inc;
    end
  end

  // Architectural state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      pc    <= RESET_VEC;
      depth <= {DEPTH_W{1'b0}};
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      pc    <= pc_next;
      depth <= depth_next;
      ovf   <= ovf_next;
      unf   <= unf_next;
    end
  end

  // Return-address storage; contents need no reset, occupancy is tracked by depth.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (nreset && push && (int'(depth) == i)) begin
        ras[i] <= pc_inc;
      end else begin
        ras[i] <= ras[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed vector table from the test plan, then
// randomized stimulus against a queue-based reference model.
module tb_fetch_seq;

  localparam int PC_W  = 11;
  localparam int SD    = 4;
  localparam int PC_MOD = 2048;
`ifdef FETCH_SEQ_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            nreset, stall, jump, call, ret, cond;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc;
  logic [2:0]      depth;
  logic            ovf, unf;

  always #5 clk = ~clk;

  fetch_seq #(.PC_W(PC_W), .STACK_DEPTH(SD), .RESET_VEC(11'h000)) dut (
    .clk(clk), .nreset(nreset), .stall(stall), .jump(jump), .call(call), .ret(ret),
    .cond(cond), .target(target), .pc(pc), .depth(depth), .ovf(ovf), .unf(unf)
  );

  typedef struct {
    bit rn, st, jp, cl, rt, cd;
    int tgt;
    int epc;
    int edp;
    bit eo, eu;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  // reference model state
  int m_pc;
  int m_q[$];
  bit m_ovf, m_unf;

  function automatic vec_t v(bit rn, bit st, bit jp, bit cl, bit rt, bit cd,
                             int tgt, int epc, int edp, bit eo, bit eu);
    vec_t r;
    r.rn = rn; r.st = st; r.jp = jp; r.cl = cl; r.rt = rt; r.cd = cd;
    r.tgt = tgt; r.epc = epc; r.edp = edp; r.eo = eo; r.eu = eu;
    return r;
  endfunction

  task automatic drive(bit rn, bit st, bit jp, bit cl, bit rt, bit cd, int tgt);
    nreset = rn; stall = st; jump = jp; call = cl; ret = rt; cond = cd;
    target = PC_W'(tgt);
  endtask

  task automatic chk(string name, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic model_step(bit rn, bit st, bit jp, bit cl, bit rt, bit cd, int tgt);
    if (!rn) begin
      m_pc = 0; m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (STALL_EN && st) begin
      // everything holds
    end else if (rt) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else begin m_pc = (m_pc + 1) % PC_MOD; m_unf = 1'b1; end
    end else if (cl && cd) begin
      if (m_q.size() < SD) m_q.push_back((m_pc + 1) % PC_MOD);
      else m_ovf = 1'b1;
      m_pc = tgt;
    end else if (jp && cd) begin
      m_pc = tgt;
    end else begin
      m_pc = (m_pc + 1) % PC_MOD;
    end
  endtask

  initial begin
    bit rn, st, jp, cl, rt, cd;
    int tgt;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // reset, idle counting
    vecs.push_back(v(0,0,0,0,0,0, 'h000, 'h000, 0, 0, 0));
    for (int i = 1; i <= 5; i++) vecs.push_back(v(1,0,0,0,0,0, 0, i, 0, 0, 0));
    // jumps, untaken jump/call
    vecs.push_back(v(1,0,1,0,0,1, 'h010, 'h010, 0, 0, 0));
    vecs.push_back(v(1,0,1,0,0,1, 'h200, 'h200, 0, 0, 0));
    vecs.push_back(v(1,0,1,0,0,0, 'h3AA, 'h201, 0, 0, 0));
    vecs.push_back(v(1,0,0,1,0,0, 'h155, 'h202, 0, 0, 0));
    // nested call/ret
    vecs.push_back(v(1,0,1,0,0,1, 'h020, 'h020, 0, 0, 0));
    vecs.push_back(v(1,0,0,1,0,1, 'h100, 'h100, 1, 0, 0));
    vecs.push_back(v(1,0,0,1,0,1, 'h300, 'h300, 2, 0, 0));
    vecs.push_back(v(1,0,0,0,1,0, 0,     'h101, 1, 0, 0));
    vecs.push_back(v(1,0,0,0,1,0, 0,     'h021, 0, 0, 0));
    // simultaneous requests: call beats jump, ret beats call
    vecs.push_back(v(1,0,1,1,0,1, 'h040, 'h040, 1, 0, 0));
    vecs.push_back(v(1,0,0,1,1,1, 'h555, 'h022, 0, 0, 0));
    // overflow then underflow
    vecs.push_back(v(1,0,0,1,0,1, 'h400, 'h400, 1, 0, 0));
    vecs.push_back(v(1,0,0,1,0,1, 'h410, 'h410, 2, 0, 0));
    vecs.push_back(v(1,0,0,1,0,1, 'h420, 'h420, 3, 0, 0));
    vecs.push_back(v(1,0,0,1,0,1, 'h430, 'h430, 4, 0, 0));
    vecs.push_back(v(1,0,0,1,0,1, 'h440, 'h440, 4, 1, 0));
    vecs.push_back(v(1,0,0,0,1,0, 0,     'h421, 3, 1, 0));
    vecs.push_back(v(1,0,0,0,1,0, 0,     'h411, 2, 1, 0));
    vecs.push_back(v(1,0,0,0,1,0, 0,     'h401, 1, 1, 0));
    vecs.push_back(v(1,0,0,0,1,0, 0,     'h023, 0, 1, 0));
    vecs.push_back(v(1,0,0,0,1,0, 0,     'h024, 0, 1, 1));
    vecs.push_back(v(1,0,0,0,0,0, 0,     'h025, 0, 1, 1));
    // wrap with sticky flags, then reset clears them
    vecs.push_back(v(1,0,1,0,0,1, 'h7FE, 'h7FE, 0, 1, 1));
    vecs.push_back(v(1,0,0,0,0,0, 0,     'h7FF, 0, 1, 1));
    vecs.push_back(v(1,0,0,0,0,0, 0,     'h000, 0, 1, 1));
    vecs.push_back(v(0,0,0,0,0,0, 0,     'h000, 0, 0, 0));
    // call from the top address returns to wrapped 0
    vecs.push_back(v(1,0,1,0,0,1, 'h7FF, 'h7FF, 0, 0, 0));
    vecs.push_back(v(1,0,0,1,0,1, 'h050, 'h050, 1, 0, 0));
    vecs.push_back(v(1,0,0,0,1,0, 0,     'h000, 0, 0, 0));
    // stall with a taken jump for 3 cycles, then resume
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(1,1,1,0,0,1, 'h333, STALL_EN ? 'h000 : 'h333, 0, 0, 0));
    vecs.push_back(v(1,0,0,0,0,0, 0, STALL_EN ? 'h001 : 'h334, 0, 0, 0));
    vecs.push_back(v(1,0,0,1,0,1, 'h060, 'h060, 1, 0, 0));
    vecs.push_back(v(1,1,0,0,1,0, 0, STALL_EN ? 'h060 : 'h335, STALL_EN ? 1 : 0, 0, 0));
    // reset wins over stall
    vecs.push_back(v(0,1,1,0,0,1, 'h123, 'h000, 0, 0, 0));
    vecs.push_back(v(1,0,0,0,0,0, 0,     'h001, 0, 0, 0));

    foreach (vecs[k]) begin
      drive(vecs[k].rn, vecs[k].st, vecs[k].jp, vecs[k].cl, vecs[k].rt, vecs[k].cd, vecs[k].tgt);
      @(posedge clk);
      #1;
      chk("vec_pc",    k, int'(pc),    vecs[k].epc);
      chk("vec_depth", k, int'(depth), vecs[k].edp);
      chk("vec_ovf",   k, int'(ovf),   int'(vecs[k].eo));
      chk("vec_unf",   k, int'(unf),   int'(vecs[k].eu));
    end

    for (int n = 0; n < 2000; n++) begin
      rn  = (n == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
      st  = ($urandom_range(0, 5) == 0);
      jp  = ($urandom_range(0, 2) == 0);
      cl  = ($urandom_range(0, 2) == 0);
      rt  = ($urandom_range(0, 2) == 0);
      cd  = ($urandom_range(0, 1) == 1);
      tgt = int'($urandom_range(0, PC_MOD - 1));
      drive(rn, st, jp, cl, rt, cd, tgt);
      @(posedge clk);
      model_step(rn, st, jp, cl, rt, cd, tgt);
      #1;
      chk("rnd_pc",    n, int'(pc),    m_pc);
      chk("rnd_depth", n, int'(depth), m_q.size());
      chk("rnd_ovf",   n, int'(ovf),   int'(m_ovf));
      chk("rnd_unf",   n, int'(unf),   int'(m_unf));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
